// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: the carry chain is cut into STAGES slices, one slice per stage.
// Latency: a beat accepted at edge N is presented after edge N+STAGES-1; sustains one beat per cycle.
// Backpressure: the whole pipe freezes while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Slice width; WIDTH must be a multiple of STAGES.
  localparam int SW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + ~cin, so a borrow-in of 1 becomes a carry-in of 0.
  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = cin ^ sub;

  // Single global advance: every stage shifts or every stage holds. This keeps
  // in_ready a function of the output register and out_ready only.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits still to be consumed when the beat enters slice k.
    localparam int RW = WIDTH - k * SW;
    // Result bits that are complete when the beat leaves slice k.
    localparam int LW = (k + 1) * SW;

    logic [RW-1:0] src_a;
    logic [RW-1:0] src_b;
    logic          src_c;
    logic          src_v;
    logic [SW-1:0] s;
    logic          c;
    logic [LW-1:0] sum_nxt;

    logic          vld;
    logic [LW-1:0] sum_r;
    logic          car_r;

    if (k == 0) begin : g_src
      // Slice 0 works straight off the ports.
      assign src_a   = a;
      assign src_b   = b_eff;
      assign src_c   = c0;
      assign src_v   = in_valid;
      assign sum_nxt = s;
    end else begin : g_src
      // Later slices take the skewed operands, the registered carry and the
      // already finished low sum bits from the previous stage.
      assign src_a   = stg[k-1].g_fwd.op_a;
      assign src_b   = stg[k-1].g_fwd.op_b;
      assign src_c   = stg[k-1].car_r;
      assign src_v   = stg[k-1].vld;
      assign sum_nxt = {s, stg[k-1].sum_r};
    end

    // One SW-bit slice of the carry chain; the extra MSB is the slice carry-out.
    assign {c, s} = {1'b0, src_a[SW-1:0]} + {1'b0, src_b[SW-1:0]} + {{SW{1'b0}}, src_c};

    // Stage register: valid, the growing low part of the sum, and the slice carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld   <= 1'b0;
        sum_r <= '0;
        car_r <= 1'b0;
      end else if (adv) begin
        vld   <= src_v;
        sum_r <= sum_nxt;
        car_r <= c;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SW-1:0] op_a;
      logic [RW-SW-1:0] op_b;

      // Carry the not-yet-added upper operand slices along with the beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_a <= '0;
          op_b <= '0;
        end else if (adv) begin
          op_a <= src_a[RW-1:SW];
          op_b <= src_b[RW-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_flg
      logic c_msb_in;
      logic ovf_r;
      logic zero_r;

      // Carry into the MSB, recovered from the MSB sum bit of the last slice.
      assign c_msb_in = src_a[SW-1] ^ src_b[SW-1] ^ s[SW-1];

      // Status flags live in the output register next to the full sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (adv) begin
          ovf_r  <= c_msb_in ^ c;
          zero_r <= (sum_nxt == '0);
        end
      end
    end
  end

  // The last stage register is the output register.
  assign out_valid = stg[STAGES-1].vld;
  assign sum       = stg[STAGES-1].sum_r;
  assign cout      = stg[STAGES-1].car_r;
  assign ovf       = stg[STAGES-1].g_flg.ovf_r;
  assign zero      = stg[STAGES-1].g_flg.zero_r;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations run side by side off one clock.
// Each has its own driver (pushes expected results on accept) and monitor (pops on consume).
// Expected values come from signed/unsigned integer arithmetic, not from the slice structure.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 1) ? 32 : ((g == 0) ? 8 : 16);
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 4 : 1);

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W+2:0] sb[$];
    bit           done = 1'b0;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .zero     (zero)
    );

    function automatic string nm(input string s);
      return $sformatf("w%0d_s%0d_%s", W, S, s);
    endfunction

    // Reference: {sum, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic op_sub);
      longint ux, uy, sx, sy, cc, ures, sres, lim, smax, smin;
      logic [W-1:0] r;
      logic co, ov;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      cc   = ci ? 64'sd1 : 64'sd0;
      lim  = longint'(1) << W;
      smax = (longint'(1) << (W - 1)) - 64'sd1;
      smin = -(longint'(1) << (W - 1));
      if (!op_sub) begin
        ures = ux + uy + cc;
        sres = sx + sy + cc;
        co   = (ures >= lim);
      end else begin
        ures = ux - uy - cc;
        sres = sx - sy - cc;
        co   = (ures >= 64'sd0);   // no borrow
      end
      ov = (sres > smax) || (sres < smin);
      r  = ures[W-1:0];
      return {r, co, ov, (r == '0)};
    endfunction

    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[W-1:0];
    endfunction

    task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = ordy;
      #1;
      if (in_valid && in_ready) sb.push_back(model(ia, ib, ic, is));
    endtask

    task automatic chk_reset_outputs(input string tag);
      chk(nm({tag, "_out_valid"}), 64'(out_valid), 64'd0);
      chk(nm({tag, "_in_ready"}), 64'(in_ready), 64'd1);
      chk(nm({tag, "_sum"}), 64'(sum), 64'd0);
      chk(nm({tag, "_flags"}), 64'({cout, ovf, zero}), 64'd0);
    endtask

    // Monitor: pops and compares on every consumed beat, plus handshake invariants.
    initial begin : mon
      logic         pstall;
      logic         exp_rdy;
      logic [W+2:0] pout;
      logic [W+2:0] got;
      logic [W+2:0] exp;
      pstall = 1'b0;
      pout   = '0;
      forever begin
        @(negedge clk);
        #2;
        got = {sum, cout, ovf, zero};
        if (rst_n === 1'b1) begin
          exp_rdy = ~out_valid | out_ready;
          chk(nm("in_ready_rule"), 64'(in_ready), 64'(exp_rdy));
          if (pstall) begin
            chk(nm("stall_valid_held"), 64'(out_valid), 64'd1);
            chk(nm("stall_data_held"), 64'(got), 64'(pout));
          end
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL %s: got=%0h expected=no beat", nm("unexpected_out"), got);
            end else begin
              exp = sb.pop_front();
              chk(nm("result"), 64'(got), 64'(exp));
            end
          end
          pstall = out_valid && !out_ready;
          pout   = got;
        end else begin
          pstall = 1'b0;
        end
      end
    end

    // Driver: directed cases, streaming, backpressure, reset mid-flight.
    initial begin : drv
      logic [W-1:0] msb;
      logic [W-1:0] ones;
      int           cnt;
      msb       = '0;
      msb[W-1]  = 1'b1;
      ones      = '1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #2;
      chk_reset_outputs("reset_init");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // All-ones + 1: carry ripples through every slice boundary; also measures latency.
      cyc(1'b1, ones, W'(1), 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      cnt = S + 5;
      for (int i = 1; i <= S + 4; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        if (out_valid) begin
          cnt = i;
          break;
        end
      end
      chk(nm("latency"), 64'(cnt), 64'(S));

      // Directed corner cases back to back.
      cyc(1'b1, msb, W'(1), 1'b0, 1'b1, 1'b1);     // most negative - 1: overflow, no borrow
      cyc(1'b1, '0, W'(1), 1'b0, 1'b1, 1'b1);      // 0 - 1: borrow
      cyc(1'b1, W'(16), W'(5), 1'b1, 1'b1, 1'b1);  // 0x10 - 0x05 - 1
      cyc(1'b1, W'(16), W'(5), 1'b1, 1'b0, 1'b1);  // 0x10 + 0x05 + 1
      cyc(1'b1, msb, msb, 1'b0, 1'b0, 1'b1);       // most negative doubled
      cyc(1'b1, ones, ones, 1'b1, 1'b1, 1'b1);     // x - x - 1
      cyc(1'b1, ones, '0, 1'b1, 1'b0, 1'b1);       // all ones + carry-in
      repeat (S + 2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Back-to-back stream, no backpressure.
      for (int i = 0; i < 100; i++) begin
        cyc(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        chk(nm("stream_in_ready"), 64'(in_ready), 64'd1);
      end

      // Random valid and random backpressure.
      for (int i = 0; i < 300; i++) begin
        cyc(1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (S + 2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk(nm("drain_empty"), 64'(sb.size()), 64'd0);

      // Reset with beats in flight and the output stalled.
      cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk_reset_outputs("reset_mid");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Nothing stale may come out after release.
      for (int i = 0; i < S + 3; i++) begin
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk(nm("no_stale_beat"), 64'(out_valid), 64'd0);
      end
      for (int i = 0; i < 40; i++) begin
        cyc(1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (S + 2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk(nm("final_empty"), 64'(sb.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin : summary
    int waited;
    waited = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 20000) begin
      total++;
      bad++;
      $display("FAIL timeout: got=%0d cycles expected=all configurations done", waited);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
